ultrasonic_ranger: RTL and testbench
====================================

// Module: ultrasonic_ranger
// PURPOSE
//  Consumes the free-running 23-bit tick count (10 ns/tick, 100 MHz) from the timebase.
//  Issues the ultrasonic trigger pulse at the start of each count wrap.
//  Measures the echo high time and converts it to whole centimetres.
//  Reports each result with a one-cycle valid strobe, plus timeout and over-range flags.
// PARAMETERS
//  CW            23         width of timebase count input
//  DW            9          width of distance output (cm)
//  TRIG_TICKS    1000       trigger high time in ticks (10 us)
//  TICKS_PER_CM  5800       ticks per cm of range (58 us round trip)
//  TIMEOUT_TICKS 6_000_000  count value at which a cycle is abandoned (60 ms); < 2**CW
//  MAX_CM        400        saturation value for distance
// PORTS
//  clk          in   1   system clock, 100 MHz
//  reset        in   1   asynchronous, active-low reset (0 = reset asserted)
//  count        in   CW  timebase tick count; increments by 1 per clk and wraps
//  echo         in   1   sensor echo, asynchronous to clk
//  trig         out  1   sensor trigger, registered
//  distance_cm  out  DW  last measured distance; holds until the next valid
//  valid        out  1   one-cycle strobe: distance_cm updated
//  timeout      out  1   one-cycle strobe: cycle abandoned, no echo edge
//  over_range   out  1   level; set with valid when result saturated, cleared on next valid
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; trig=0, distance_cm=0, valid=0, timeout=0, over_range=0.
//   Synchronizer, prescaler and cm counter are cleared.
//  echo passes through a 2-FF synchronizer (echo_s). Edge detection compares echo_s to a 3rd flop.
//  FSM (one transition per clk):
//   IDLE: on count==0 -> TRIG, trig<=1.
//   TRIG: trig=1 while count<TRIG_TICKS. At count==TRIG_TICKS -> WAIT_ECHO, trig<=0 (exactly 1000 ticks high).
//   WAIT_ECHO: on an echo_s rising edge -> MEASURE, clear prescaler and cm counter.
//    An echo already high on entry is ignored; a real rising edge is required.
//    On count==TIMEOUT_TICKS -> IDLE, timeout<=1 for 1 cycle.
//   MEASURE: each clk with echo_s=1, prescaler++.
//    When the prescaler reaches TICKS_PER_CM-1: prescaler<=0, cm++. cm saturates at MAX_CM.
//    On an echo_s falling edge -> DONE.
//    On count==TIMEOUT_TICKS with no fall -> IDLE, timeout<=1.
//   DONE: distance_cm<=cm, over_range<=(cm==MAX_CM), valid<=1 for 1 cycle -> IDLE.
//  Result is floor(high_ticks/TICKS_PER_CM), saturated at MAX_CM.
//  Latency: valid asserts 4 clk after the raw echo fall (2 sync, 1 edge, 1 DONE).
//  Simultaneous events: an echo fall in the same cycle as count==TIMEOUT_TICKS is a valid result; timeout is not raised.
//  valid and timeout are never high together. timeout leaves distance_cm and over_range unchanged.
//  count wrap: TIMEOUT_TICKS < 2**CW guarantees a return to IDLE before the next count==0.
//   A count==0 seen outside IDLE is ignored.
//  Prescaler width = $clog2(TICKS_PER_CM). cm counter width = DW. No wider arithmetic.
// STRUCTURE
//  ultra_pkg: typedef enum logic [2:0] {IDLE,TRIG,WAIT_ECHO,MEASURE,DONE} ultra_state_t;
//   also holds the default constants TRIG_TICKS, TICKS_PER_CM, TIMEOUT_TICKS, MAX_CM.
//  Sub-module: sync_2ff (1-bit, async active-low reset to 0), instanced for echo.
//  FSM, prescaler, cm counter and output registers live in this module.
// TESTING
//  Bench drives count from a model of the timebase (0,1,2,... wrapping at 2**23).
//  1 Trigger: release reset, run to count==0
//    -> trig high for exactly 1000 clk, rising 1 clk after count==0.
//  2 Nominal: echo high 58000 clk after trigger
//    -> valid once, distance_cm=10, over_range=0; 5799 clk -> distance_cm=0.
//  3 No echo: echo held 0
//    -> timeout strobe 1 clk after count==6_000_000; distance_cm keeps its prior value; no valid.
//  4 Over-range: echo high 2_400_000 clk -> distance_cm=400, over_range=1.
//    Next echo of 116000 clk -> distance_cm=20, over_range=0.
//  5 Race and stale echo: echo falling in the cycle count==6_000_000 -> valid, no timeout.
//    echo high before count==0 and never re-rising -> timeout.
//  6 Reset mid-MEASURE: assert reset at 30000 clk into echo
//    -> all outputs 0 immediately; after release, next count==0 starts a clean cycle.

Source files
------------

// File: rtl/ultra_pkg.sv
// Shared types and default timing constants for the ultrasonic ranger.
package ultra_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    DONE
  } ultra_state_t;

  localparam int TRIG_TICKS    = 1000;       // 10 us trigger pulse at 100 MHz
  localparam int TICKS_PER_CM  = 5800;       // 58 us round trip per cm
  localparam int TIMEOUT_TICKS = 6_000_000;  // 60 ms, cycle abandoned
  localparam int MAX_CM        = 400;        // distance saturation value

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // capture the asynchronous input through two flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ultrasonic_ranger.sv
// Ultrasonic ranger: trigger generation, echo timing and cm conversion.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for the timebase count to wrap to 0
// TRIG      | trigger pulse high until count reaches TRIG_TICKS
// WAIT_ECHO | waiting for a fresh echo rising edge, or the timeout count
// MEASURE   | echo high: prescaler divides ticks into cm, waits for fall
// DONE      | publish distance/over_range with a one-cycle valid
module ultrasonic_ranger #(
  parameter int CW            = 23,
  parameter int DW            = 9,
  parameter int TRIG_TICKS    = ultra_pkg::TRIG_TICKS,
  parameter int TICKS_PER_CM  = ultra_pkg::TICKS_PER_CM,
  parameter int TIMEOUT_TICKS = ultra_pkg::TIMEOUT_TICKS,
  parameter int MAX_CM        = ultra_pkg::MAX_CM
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CW-1:0] count,
  input  logic          echo,
  output logic          trig,
  output logic [DW-1:0] distance_cm,
  output logic          valid,
  output logic          timeout,
  output logic          over_range
);

  import ultra_pkg::*;

  localparam int PW = (TICKS_PER_CM > 1) ? $clog2(TICKS_PER_CM) : 1;

  localparam logic [CW-1:0] TRIG_C    = CW'(TRIG_TICKS);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_TICKS);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_CM - 1);
  localparam logic [PW-1:0] PRE_FIRST = PW'(1);
  localparam logic [DW-1:0] CM_MAX    = DW'(MAX_CM);

  ultra_state_t  state;
  logic          echo_s;
  logic          echo_d;
  logic          echo_rise;
  logic          echo_fall;
  logic [PW-1:0] prescaler;
  logic [DW-1:0] cm;

  sync_2ff u_echo_sync (
    .clk   (clk),
    .reset (reset),
    .d     (echo),
    .q     (echo_s)
  );

  // delayed copy of the synchronized echo for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_d <= 1'b0;
    end else begin
      echo_d <= echo_s;
    end
  end

  assign echo_rise = echo_s & ~echo_d;
  assign echo_fall = ~echo_s & echo_d;

  // sequencing FSM with prescaler, cm counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      trig        <= 1'b0;
      distance_cm <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      over_range  <= 1'b0;
      prescaler   <= '0;
      cm          <= '0;
    end else begin
      valid   <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (count == '0) begin
            state <= TRIG;
            trig  <= 1'b1;
          end
        end
        TRIG: begin
          if (count == TRIG_C) begin
            state <= WAIT_ECHO;
            trig  <= 1'b0;
          end
        end
        WAIT_ECHO: begin
          if (count == TIMEOUT_C) begin
            state   <= IDLE;
            timeout <= 1'b1;
          end else if (echo_rise) begin
            // the rising-edge cycle is already the first high tick
            state     <= MEASURE;
            prescaler <= PRE_FIRST;
            cm        <= '0;
          end
        end
        MEASURE: begin
          // an echo fall wins over a coincident timeout count
          if (echo_fall) begin
            state <= DONE;
          end else if (count == TIMEOUT_C) begin
            state   <= IDLE;
            timeout <= 1'b1;
          end else if (echo_s) begin
            if (prescaler == PRE_LAST) begin
              prescaler <= '0;
              if (cm != CM_MAX) cm <= cm + 1'b1;
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
        end
        DONE: begin
          distance_cm <= cm;
          over_range  <= (cm == CM_MAX);
          valid       <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
          trig  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with a jumpable timebase model.
module tb_ultrasonic_ranger;

  localparam int TPC     = 58;          // ticks per cm, scaled down by 100
  localparam int TMO     = 6_000_000;

  logic        clk;
  logic        reset;
  logic [22:0] count;
  logic        echo;
  logic        trig;
  logic [8:0]  distance_cm;
  logic        valid;
  logic        timeout;
  logic        over_range;

  int total = 0;
  int bad   = 0;

  ultrasonic_ranger #(.TICKS_PER_CM(TPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .count       (count),
    .echo        (echo),
    .trig        (trig),
    .distance_cm (distance_cm),
    .valid       (valid),
    .timeout     (timeout),
    .over_range  (over_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #(10 * 200_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // one clock: outputs settle, then the timebase advances
  task automatic step();
    @(posedge clk);
    #1;
    count = count + 23'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // wrap the timebase and wait out a full trigger pulse
  task automatic trigger_cycle();
    int n;
    count = 23'h7FFFFC;
    n = 0;
    while (!trig && n < 20) begin step(); n++; end
    chk("trig_start", trig, 1);
    n = 0;
    while (trig && n < 1100) begin step(); n++; end
    chk("trig_end", trig, 0);
  endtask

  // echo high for h clocks, then expect valid exactly 4 clocks after the fall
  task automatic measure(input int h, input int exp_cm, input int exp_or);
    echo = 1'b1;
    repeat (h) step();
    echo = 1'b0;
    repeat (3) step();
    chk("valid_early", valid, 0);
    step();
    chk("valid", valid, 1);
    chk("timeout_with_valid", timeout, 0);
    chk("distance", distance_cm, exp_cm);
    chk("over_range", over_range, exp_or);
    step();
    chk("valid_one_cycle", valid, 0);
  endtask

  initial begin
    int n;
    reset = 1'b0;
    echo  = 1'b0;
    count = 23'd5;

    // reset state
    repeat (3) step();
    chk("rst_trig", trig, 0);
    chk("rst_valid", valid, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_distance", distance_cm, 0);
    chk("rst_over_range", over_range, 0);
    reset = 1'b1;
    repeat (2) step();

    // 1: trigger exactly 1000 clocks, rising 1 clk after count==0
    count = 23'h7FFFFD;
    repeat (3) step();
    chk("trig_before_wrap", trig, 0);
    step();
    chk("trig_after_zero", trig, 1);
    n = 1;
    while (trig && n < 2000) begin
      step();
      if (trig) n++;
    end
    chk("trig_width", n, 1000);

    // 2: nominal and cm boundaries
    measure(10 * TPC, 10, 0);
    trigger_cycle();
    measure(TPC - 1, 0, 0);
    trigger_cycle();
    measure(TPC, 1, 0);

    // 4a: over-range saturation
    trigger_cycle();
    measure(24_000, 400, 1);

    // 3: no echo -> timeout, result registers untouched
    trigger_cycle();
    count = 23'(TMO - 3);
    repeat (3) step();
    chk("timeout_early", timeout, 0);
    step();
    chk("timeout_strobe", timeout, 1);
    chk("timeout_no_valid", valid, 0);
    chk("timeout_keeps_distance", distance_cm, 400);
    chk("timeout_keeps_over_range", over_range, 1);
    step();
    chk("timeout_one_cycle", timeout, 0);

    // 4b: next normal result clears over_range
    trigger_cycle();
    measure(20 * TPC, 20, 0);

    // 5a: echo fall seen in the same cycle as the timeout count
    trigger_cycle();
    echo = 1'b1;
    repeat (100) step();
    count = 23'(TMO - 2);
    echo = 1'b0;
    repeat (3) step();
    chk("race_no_timeout", timeout, 0);
    step();
    chk("race_valid", valid, 1);
    chk("race_timeout", timeout, 0);
    chk("race_distance", distance_cm, 1);
    step();
    chk("race_after_timeout", timeout, 0);

    // 5b: echo already high before the trigger never re-rises -> timeout
    echo = 1'b1;
    repeat (4) step();
    trigger_cycle();
    count = 23'(TMO - 1);
    step();
    chk("stale_early", timeout, 0);
    step();
    chk("stale_timeout", timeout, 1);
    chk("stale_no_valid", valid, 0);
    echo = 1'b0;
    repeat (3) step();

    // 6: asynchronous reset in the middle of a measurement
    trigger_cycle();
    echo = 1'b1;
    repeat (300) step();
    reset = 1'b0;
    #1;
    chk("mid_rst_trig", trig, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_timeout", timeout, 0);
    chk("mid_rst_distance", distance_cm, 0);
    chk("mid_rst_over_range", over_range, 0);
    echo = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();
    trigger_cycle();
    measure(10 * TPC, 10, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
